// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a valid/ready load/store port.
// Each access is answered a fixed LATENCY cycles after it is accepted.
//
//  state | meaning
//  ------+-------------------------------------------------------
//  IDLE  | req_ready=1, waiting for a request
//  WAIT  | request latched, counter running down to the access
//  RESP  | rsp_valid=1, result held until rsp_ready
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_f3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            lat_we;
    logic [2:0]      lat_f3;
    logic [AW+1:0]   lat_addr;
    logic [31:0]     lat_wdata;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic            access_now;
    logic [AW-1:0]   word_idx;
    logic [1:0]      lane;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     ld_data;
    logic [31:0]     st_data;
    logic [3:0]      st_mask;
    logic            acc_err;

    // Address bits above the array wrap around and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    assign req_ready  = (state == IDLE);
    assign rsp_valid  = (state == RESP);
    assign accept     = (state == IDLE) && req_valid;
    assign access_now = (state == WAIT) && (cnt == '0);

    assign word_idx = lat_addr[AW+1:2];
    assign lane     = lat_addr[1:0];
    assign rd_word  = mem[word_idx];
    assign rd_byte  = rd_word[{lane, 3'b000} +: 8];
    assign rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        acc_err = 1'b0;
        ld_data = '0;
        st_data = '0;
        st_mask = '0;
        if (lat_we) begin
            case (lat_f3)
                3'b000: begin
                    st_data = {4{lat_wdata[7:0]}};
                    st_mask = 4'b0001 << lane;
                end
                3'b001: begin
                    st_data = {2{lat_wdata[15:0]}};
                    st_mask = lane[1] ? 4'b1100 : 4'b0011;
                    acc_err = lane[0];
                end
                3'b010: begin
                    st_data = lat_wdata;
                    st_mask = 4'b1111;
                    acc_err = (lane != 2'b00);
                end
                default: acc_err = 1'b1;
            endcase
        end else begin
            case (lat_f3)
                3'b000: ld_data = {{24{rd_byte[7]}}, rd_byte};
                3'b001: begin
                    ld_data = {{16{rd_half[15]}}, rd_half};
                    acc_err = lane[0];
                end
                3'b010: begin
                    ld_data = rd_word;
                    acc_err = (lane != 2'b00);
                end
                3'b100: ld_data = {24'h0, rd_byte};
                3'b101: begin
                    ld_data = {16'h0, rd_half};
                    acc_err = lane[0];
                end
                default: acc_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_f3    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_f3    <= req_f3;
                lat_addr  <= req_addr[AW+1:0];
                lat_wdata <= req_wdata;
                cnt       <= CW'(LATENCY - 1);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
            if (access_now) begin
                rsp_rdata <= (acc_err || lat_we) ? 32'h0 : ld_data;
                rsp_err   <= acc_err;
            end
        end
    end

    // No reset on the array: contents survive reset by design.
    always_ff @(posedge clk) begin
        if (access_now && lat_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (st_mask[i]) mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder against a byte-addressed
// reference memory, plus directed cases for latency, errors, backpressure and reset.
module tb_data_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_f3 = 3'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_mem [0:4*DEPTH-1];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_f3    (req_f3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Little-endian byte memory; size and sign come straight from funct3.
    function automatic void model_access(input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [31:0] wdata,
                                         output logic [31:0] rd, output logic err);
        int a;
        int size;
        logic legal;
        a     = int'(addr[9:0]);
        size  = 1 << f3[1:0];
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err   = !legal || ((a % size) != 0);
        rd    = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[a+i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) rd = rd | (32'(ref_mem[a+i]) << (8*i));
                if (!f3[2] && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8*size));
            end
        end
    endfunction

    task automatic send(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
        int w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("req_ready_wait", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_f3    = f3;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        // Garbage on the request fields after acceptance must be ignored.
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_f3    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
    endtask

    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold, input string tag,
                          output logic [31:0] obs_rd, output logic obs_err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        model_access(we, f3, addr, wdata, exp_rd, exp_err);
        send(we, f3, addr, wdata);
        wait_rsp(lat);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_rd"}, rsp_rdata, exp_rd);
        check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        obs_rd  = rsp_rdata;
        obs_err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, {31'b0, rsp_valid}, 32'd1);
            check({tag, "_hold_rd"}, rsp_rdata, exp_rd);
            check({tag, "_hold_ready"}, {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_drop"}, {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] obs;
        logic        oerr;
        logic [31:0] e_rd;
        logic        e_err;
        int          lat;
        logic [2:0]  f3;
        logic [31:0] addr;

        #2 reset = 1'b1;
        #2;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Give every word a known value so the model and the array agree.
        for (int i = 0; i < DEPTH; i++) access(1'b1, 3'b010, 32'(i*4), $urandom, 0, "init", obs, oerr);

        access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, "sw_10", obs, oerr);
        access(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_10", obs, oerr);
        check("lw_10_const", obs, 32'hDEADBEEF);
        access(1'b1, 3'b000, 32'h13, 32'h80, 0, "sb_13", obs, oerr);
        access(1'b0, 3'b000, 32'h13, 32'h0, 1, "lb_13", obs, oerr);
        check("lb_13_const", obs, 32'hFFFFFF80);
        access(1'b0, 3'b100, 32'h13, 32'h0, 0, "lbu_13", obs, oerr);
        check("lbu_13_const", obs, 32'h00000080);
        access(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_10b", obs, oerr);
        check("lw_10b_const", obs, 32'h80ADBEEF);
        access(1'b0, 3'b001, 32'h11, 32'h0, 0, "lh_11", obs, oerr);
        check("lh_11_err", {31'b0, oerr}, 32'd1);
        check("lh_11_rd0", obs, 32'h0);
        access(1'b1, 3'b010, 32'h12, 32'h0, 0, "sw_12", obs, oerr);
        check("sw_12_err", {31'b0, oerr}, 32'd1);
        access(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw_10c", obs, oerr);
        check("lw_10c_const", obs, 32'h80ADBEEF);
        access(1'b0, 3'b011, 32'h10, 32'h0, 0, "ld_f3_011", obs, oerr);
        check("ld_f3_011_err", {31'b0, oerr}, 32'd1);

        // Backpressure with a second request already waiting.
        model_access(1'b0, 3'b010, 32'h10, 32'h0, e_rd, e_err);
        send(1'b0, 3'b010, 32'h10, 32'h0);
        wait_rsp(lat);
        check("bp_lat", lat, LAT);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_f3    = 3'b100;
        req_addr  = 32'h13;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_rdata", rsp_rdata, 32'h80ADBEEF);
            check("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_hs_valid", {31'b0, rsp_valid}, 32'd0);
        check("bp_hs_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        check("bp_second_acc", {31'b0, req_ready}, 32'd0);
        req_valid = 1'b0;
        model_access(1'b0, 3'b100, 32'h13, 32'h0, e_rd, e_err);
        wait_rsp(lat);
        check("bp2_lat", lat, LAT);
        check("bp2_rd", rsp_rdata, e_rd);
        check("bp2_const", rsp_rdata, 32'h80);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset during WAIT discards a pending store.
        access(1'b1, 3'b010, 32'h20, 32'hAAAAAAAA, 0, "sw_20", obs, oerr);
        send(1'b1, 3'b010, 32'h20, 32'h12345678);
        reset = 1'b1;
        #1;
        check("rw_valid", {31'b0, rsp_valid}, 32'd0);
        check("rw_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rw_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        access(1'b0, 3'b010, 32'h20, 32'h0, 0, "lw_20", obs, oerr);
        check("lw_20_const", obs, 32'hAAAAAAAA);

        // Reset during RESP drops the response.
        send(1'b0, 3'b010, 32'h10, 32'h0);
        wait_rsp(lat);
        reset = 1'b1;
        #1;
        check("rr_valid", {31'b0, rsp_valid}, 32'd0);
        check("rr_rdata", rsp_rdata, 32'h0);
        check("rr_err", {31'b0, rsp_err}, 32'd0);
        check("rr_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        access(1'b1, 3'b010, 32'h400, 32'h0BADF00D, 0, "sw_400", obs, oerr);
        access(1'b0, 3'b010, 32'h000, 32'h0, 0, "lw_000", obs, oerr);
        check("wrap_const", obs, 32'h0BADF00D);

        for (int n = 0; n < 300; n++) begin
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
                if (f3[1:0] == 2'b01) addr[0] = 1'b0;
            end
            access(1'($urandom), f3, addr, $urandom, $urandom_range(0, 2), "rnd", obs, oerr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
